pdm_demod: RTL and testbench

- PDM demodulator: recovers a 16-bit unsigned duty value from a 1-bit pulse-density stream, such as the stream produced by the team's PDM modulator.
- Integrate-and-dump decimator: counts ones over a fixed power-of-two window, then scales the count to 16 bits.
- Sits on the receive side of a PDM link, or in loopback for modulator self-test; results go to downstream control logic through a valid/ready handshake.

---
 rtl/pdm_demod.sv | 160 ++++++++++++++++
 tb/tb_pdm_demod.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_demod.sv
// pdm_demod: integrate-and-dump PDM demodulator with a valid/ready result port and sticky overrun.
// Define PDM_DEMOD_AVG_EN to add a registered 4-tap moving average behind the decimator (+1 clk latency).
module pdm_demod #(
  parameter int WIN_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pdm,
  input  logic        en,
  output logic [15:0] duty,
  output logic        duty_vld,
  input  logic        duty_rdy,
  output logic        ovr,
  input  logic        ovr_clr
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DUMP  = 2'd2;

  localparam logic [WIN_LOG2-1:0] CNT_ONE = 1;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic                pdm_meta;
  logic                pdm_sync;
  logic [WIN_LOG2-1:0] cnt;
  logic [WIN_LOG2:0]   acc;
  logic [WIN_LOG2:0]   sample_ext;
  logic [15:0]         win_res;
  logic                dump;
  logic                res_stb;
  logic [15:0]         res_val;

  // Two-flop synchronizer; pdm is not related to clk.
  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pdm_meta <= 1'b0;
      pdm_sync <= 1'b0;
    end else begin
      pdm_meta <= pdm;
      pdm_sync <= pdm_meta;
    end
  end

  assign sample_ext = {{WIN_LOG2{1'b0}}, pdm_sync};
  assign dump       = (state == ST_DUMP);

  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      ST_IDLE:  if (en) state_nxt = ST_ACCUM;
      ST_ACCUM: begin
        if (!en)       state_nxt = ST_IDLE;
        else if (&cnt) state_nxt = ST_DUMP;
      end
      ST_DUMP:  state_nxt = en ? ST_ACCUM : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // The DUMP cycle already counts the first sample of the next window, so none is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_ACCUM: begin
          if (en) begin
            cnt <= cnt + CNT_ONE;
            acc <= acc + sample_ext;
          end else begin
            cnt <= '0;
            acc <= '0;
          end
        end
        ST_DUMP: begin
          if (en) begin
            cnt <= CNT_ONE;
            acc <= sample_ext;
          end else begin
            cnt <= '0;
            acc <= '0;
          end
        end
        default: begin
          cnt <= '0;
          acc <= '0;
        end
      endcase
    end
  end

  // acc's top bit is set only for a full window of ones, which does not fit 16 bits after scaling.
  always_comb begin
    win_res = 16'(acc) << (16 - WIN_LOG2);
    if (acc[WIN_LOG2]) win_res = 16'hFFFF;
  end

`ifdef PDM_DEMOD_AVG_EN
  logic [15:0] hist0;
  logic [15:0] hist1;
  logic [15:0] hist2;
  logic [17:0] avg_sum;
  logic [15:0] avg_val;
  logic        avg_stb;

  assign avg_sum = {2'b00, win_res} + {2'b00, hist0} + {2'b00, hist1} + {2'b00, hist2};

  // History survives en=0; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist0   <= '0;
      hist1   <= '0;
      hist2   <= '0;
      avg_val <= '0;
      avg_stb <= 1'b0;
    end else begin
      avg_stb <= dump;
      if (dump) begin
        hist2   <= hist1;
        hist1   <= hist0;
        hist0   <= win_res;
        avg_val <= avg_sum[17:2];
      end
    end
  end

  assign res_stb = avg_stb;
  assign res_val = avg_val;
`else
  assign res_stb = dump;
  assign res_val = win_res;
`endif

  // A new result always wins over a same-cycle handshake; it only counts as overrun if unconsumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty     <= '0;
      duty_vld <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      if (res_stb) begin
        duty     <= res_val;
        duty_vld <= 1'b1;
      end else if (duty_vld && duty_rdy) begin
        duty_vld <= 1'b0;
      end

      if (res_stb && duty_vld && !duty_rdy) ovr <= 1'b1;
      else if (ovr_clr)                      ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pdm_demod.sv
// tb_pdm_demod: table-driven and scoreboard checks of pdm_demod with WIN_LOG2=8.
// Honours PDM_DEMOD_AVG_EN for the expected values and the extra clk of latency.
`timescale 1ns/1ps
module tb_pdm_demod;

`ifdef PDM_DEMOD_AVG_EN
  localparam int LAT = 259;
`else
  localparam int LAT = 258;
`endif

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        pdm      = 1'b0;
  logic        en       = 1'b0;
  logic        duty_rdy = 1'b0;
  logic        ovr_clr  = 1'b0;
  logic [15:0] duty;
  logic        duty_vld;
  logic        ovr;

  pdm_demod #(.WIN_LOG2(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .pdm      (pdm),
    .en       (en),
    .duty     (duty),
    .duty_vld (duty_vld),
    .duty_rdy (duty_rdy),
    .ovr      (ovr),
    .ovr_clr  (ovr_clr)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Periodic 16-bit pattern; any 256-sample window holds popcount*16 ones whatever the phase.
  logic [15:0] pat = 16'h0000;
  int          ph  = 0;
  initial forever begin
    @(negedge clk);
    pdm = pat[ph[3:0]];
    ph  = (ph + 1) % 16;
  end

  // Reference model for the optional averaging stage.
  logic [15:0] h0 = '0, h1 = '0, h2 = '0;
  task automatic exp_of(input logic [15:0] w, output logic [15:0] e);
`ifdef PDM_DEMOD_AVG_EN
    logic [17:0] s;
    s  = {2'b00, w} + {2'b00, h0} + {2'b00, h1} + {2'b00, h2};
    e  = s[17:2];
    h2 = h1;
    h1 = h0;
    h0 = w;
`else
    e = w;
`endif
  endtask

  typedef struct {
    logic [15:0] val;
    int          due;
  } exp_t;
  exp_t sbq[$];
  bit   mon_en = 1'b0;

  task automatic push_exp(input logic [15:0] w, input int due);
    exp_t x;
    exp_of(w, x.val);
    x.due = due;
    sbq.push_back(x);
  endtask

  // Consumer side: with duty_rdy=1 each result is visible for exactly one cycle.
  initial forever begin
    exp_t x;
    @(negedge clk);
    if (mon_en && !rst && duty_vld && duty_rdy) begin
      if (sbq.size() == 0) begin
        check("unexpected_vld", {31'd0, duty_vld}, 32'd0);
      end else begin
        x = sbq.pop_front();
        check("sb_duty", {16'd0, duty}, {16'd0, x.val});
        check("sb_cycle", cyc, x.due);
      end
    end
  end

  task automatic wait_drain(input int max);
    for (int k = 0; k < max && sbq.size() != 0; k++) @(negedge clk);
    check("sb_drain", sbq.size(), 0);
  endtask

  task automatic wait_vld(input int max);
    for (int k = 0; k < max && !duty_vld; k++) @(negedge clk);
  endtask

  task automatic wait_ovr(input int max);
    for (int k = 0; k < max && !ovr; k++) @(negedge clk);
  endtask

  task automatic settle(input logic [15:0] p);
    @(negedge clk);
    en  = 1'b0;
    pat = p;
    repeat (20) @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] pat;
    logic [15:0] win;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] e1, e2, keep;
    int          seen;

    vecs[0] = '{pat: 16'hFFFF, win: 16'hFFFF};
    vecs[1] = '{pat: 16'h0000, win: 16'h0000};
    vecs[2] = '{pat: 16'h5555, win: 16'h8000};
    vecs[3] = '{pat: 16'h1111, win: 16'h4000};
    vecs[4] = '{pat: 16'h7777, win: 16'hC000};
    vecs[5] = '{pat: 16'h0001, win: 16'h1000};
    vecs[6] = '{pat: 16'h7FFF, win: 16'hF000};
    vecs[7] = '{pat: 16'h00FF, win: 16'h8000};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_duty", {16'd0, duty}, 32'd0);
    check("rst_vld", {31'd0, duty_vld}, 32'd0);
    check("rst_ovr", {31'd0, ovr}, 32'd0);
    rst = 1'b0;

    // One isolated window per table entry, consumed immediately
    mon_en   = 1'b1;
    duty_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle(vecs[i].pat);
      push_exp(vecs[i].win, cyc + LAT);
      en = 1'b1;
      wait_drain(400);
    end

    // Back-to-back windows: one result every 256 clk
    settle(16'hFFFF);
    push_exp(16'hFFFF, cyc + LAT);
    push_exp(16'hFFFF, cyc + LAT + 256);
    push_exp(16'hFFFF, cyc + LAT + 512);
    en = 1'b1;
    wait_drain(900);

    // Overrun: two unconsumed results, ones then zeros
    mon_en   = 1'b0;
    duty_rdy = 1'b0;
    settle(16'hFFFF);
    exp_of(16'hFFFF, e1);
    en = 1'b1;
    wait_vld(400);
    check("ovr_first_vld", {31'd0, duty_vld}, 32'd1);
    check("ovr_first_duty", {16'd0, duty}, {16'd0, e1});
    check("ovr_not_yet", {31'd0, ovr}, 32'd0);
    settle(16'h0000);
    exp_of(16'h0000, e2);
    en = 1'b1;
    wait_ovr(400);
    en = 1'b0;
    check("ovr_set", {31'd0, ovr}, 32'd1);
    check("ovr_second_duty", {16'd0, duty}, {16'd0, e2});
    check("ovr_vld_held", {31'd0, duty_vld}, 32'd1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("ovr_cleared", {31'd0, ovr}, 32'd0);
    check("vld_after_clr", {31'd0, duty_vld}, 32'd1);
    duty_rdy = 1'b1;
    @(negedge clk);
    duty_rdy = 1'b0;
    check("vld_after_hs", {31'd0, duty_vld}, 32'd0);

    // en dropped after 100 samples: no result, duty retained; re-raise gives a full window
    keep     = duty;
    duty_rdy = 1'b1;
    mon_en   = 1'b1;
    settle(16'hFFFF);
    en = 1'b1;
    repeat (101) @(negedge clk);
    en   = 1'b0;
    seen = 0;
    repeat (400) begin
      @(negedge clk);
      if (duty_vld) seen++;
    end
    check("abort_no_vld", seen, 0);
    check("abort_duty_kept", {16'd0, duty}, {16'd0, keep});
    push_exp(16'hFFFF, cyc + LAT);
    en = 1'b1;
    wait_drain(400);

    // Asynchronous reset in the middle of a window with vld and ovr both set
    mon_en   = 1'b0;
    duty_rdy = 1'b0;
    settle(16'hFFFF);
    exp_of(16'hFFFF, e1);
    en = 1'b1;
    wait_vld(400);
    exp_of(16'hFFFF, e1);
    wait_ovr(400);
    check("pre_rst_ovr", {31'd0, ovr}, 32'd1);
    repeat (50) @(negedge clk);
    #3;
    rst = 1'b1;
    en  = 1'b0;
    #1;
    check("midrst_duty", {16'd0, duty}, 32'd0);
    check("midrst_vld", {31'd0, duty_vld}, 32'd0);
    check("midrst_ovr", {31'd0, ovr}, 32'd0);
    h0 = '0;
    h1 = '0;
    h2 = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    duty_rdy = 1'b1;
    mon_en   = 1'b1;
    push_exp(16'hFFFF, cyc + LAT);
    push_exp(16'hFFFF, cyc + LAT + 256);
    en = 1'b1;
    wait_drain(700);
    en = 1'b0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
